kbd_line_ctrl: RTL

Line-assembly controller that sits between the PS/2 keyboard driver and downstream text consumers (display writer, command parser). It turns the driver's held 16-bit ASCII word into single key events and assembles printable characters into a line buffer with backspace editing. On Enter it sequences the buffered line out over a valid/ready byte stream. While draining, it locks out new keystrokes.

---
 rtl/kbd_line_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/kbd_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kbd_line_ctrl
// Brief    : Key-event detect, line buffer with backspace, valid/ready drain.
// Revision : 1.0
// ============================================================================
module kbd_line_ctrl #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic [LEN_W-1:0] line_len,
    output logic             busy,
    output logic             overflow
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] c_len_max = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_len_zero = '0;

    typedef enum logic [0:0] {
        S_EDIT  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_key;
    logic             r_flag;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_rd_ptr;
    logic             r_ovf;
    logic [7:0]       r_buf [DEPTH];

    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] w_rd_nxt;
    logic             w_ovf_nxt;
    logic             w_wr_en;
    logic             w_evt;
    logic [7:0]       w_code;
    logic             w_printable;
    logic             w_last;

    // One event per rising edge of the registered valid flag.
    assign w_evt       = r_key[15] & ~r_flag;
    assign w_code      = r_key[7:0];
    assign w_printable = (w_code >= 8'h20) && (w_code <= 8'h7E);
    assign w_last      = (r_rd_ptr == (r_len - c_len_one));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EDIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_rd_nxt    = r_rd_ptr;
        w_ovf_nxt   = r_ovf;
        w_wr_en     = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        out_char    = 8'h00;
        out_last    = 1'b0;

        case (r_state)
            S_EDIT: begin
                if (w_evt) begin
                    if (w_printable) begin
                        if (r_len < c_len_max) begin
                            w_wr_en   = 1'b1;
                            w_len_nxt = r_len + c_len_one;
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                    end else if (w_code == 8'h08) begin
                        if (r_len != c_len_zero) begin
                            w_len_nxt = r_len - c_len_one;
                        end
                    end else if (w_code == 8'h0D) begin
                        if (r_len != c_len_zero) begin
                            w_rd_nxt    = c_len_zero;
                            w_state_nxt = S_DRAIN;
                        end else begin
                            w_ovf_nxt = 1'b0;
                        end
                    end
                end
            end

            S_DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_char  = r_buf[r_rd_ptr[ADDR_W-1:0]];
                out_last  = w_last;
                if (w_evt) begin
                    w_ovf_nxt = 1'b1;
                end
                // End-of-line clear is assigned last so it overrides a same-edge drop.
                if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt = S_EDIT;
                        w_len_nxt   = c_len_zero;
                        w_ovf_nxt   = 1'b0;
                    end else begin
                        w_rd_nxt = r_rd_ptr + c_len_one;
                    end
                end
            end

            default: begin
                w_state_nxt = S_EDIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key    <= 16'h0000;
            r_flag   <= 1'b0;
            r_len    <= c_len_zero;
            r_rd_ptr <= c_len_zero;
            r_ovf    <= 1'b0;
        end else begin
            r_key    <= key_in;
            r_flag   <= r_key[15];
            r_len    <= w_len_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_len[ADDR_W-1:0]] <= w_code;
        end
    end

    assign line_len = r_len;
    assign overflow = r_ovf;

endmodule
`default_nettype wire
